// File: rtl/gp_reservation_station.sv
// Reservation station for GP instructions: buffers dispatched ops,
// snoops the result broadcast by RS tag and issues ready ops in index order.
module gp_reservation_station #(
  parameter int DEPTH        = 4,
  parameter int RS_ID_WIDTH  = 5,
  parameter int RS_BASE_ID   = 1,
  parameter int OPCODE_WIDTH = 6
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        dispatch_valid,
  output logic                        dispatch_ready,
  output logic [RS_ID_WIDTH-1:0]      dispatch_rs_id,
  input  logic [OPCODE_WIDTH-1:0]     dispatch_opcode,
  input  logic [4:0]                  dispatch_dest_addr,
  input  logic [1:0]                  dispatch_op_valid,
  input  logic [1:0][31:0]            dispatch_op_value,
  input  logic [1:0][RS_ID_WIDTH-1:0] dispatch_op_rs_id,
  input  logic                        result_valid,
  input  logic [RS_ID_WIDTH-1:0]      result_rs_id,
  input  logic [31:0]                 result_value,
  output logic                        issue_valid,
  input  logic                        issue_ready,
  output logic [OPCODE_WIDTH-1:0]     issue_opcode,
  output logic [4:0]                  issue_dest_addr,
  output logic [1:0][31:0]            issue_op_value,
  output logic [RS_ID_WIDTH-1:0]      issue_rs_id
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic                          busy;
    logic [OPCODE_WIDTH-1:0]       opcode;
    logic [4:0]                    dest;
    logic [1:0]                    vld;
    logic [1:0][31:0]              val;
    logic [1:0][RS_ID_WIDTH-1:0]   tag;
  } entry_t;

  entry_t ent [DEPTH];

  logic                   free_any;
  logic [IW-1:0]          free_idx;
  logic                   rdy_any;
  logic [IW-1:0]          rdy_idx;
  logic [RS_ID_WIDTH-1:0] free_tag;
  logic [RS_ID_WIDTH-1:0] last_tag;
  logic                   disp_fire;
  logic                   issue_fire;

  // Priority-find lowest free entry and lowest ready entry.
  always_comb begin
    free_any = 1'b0;
    free_idx = '0;
    rdy_any  = 1'b0;
    rdy_idx  = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!ent[i].busy) begin
        free_any = 1'b1;
        free_idx = IW'(i);
      end
      if (ent[i].busy && (&ent[i].vld)) begin
        rdy_any = 1'b1;
        rdy_idx = IW'(i);
      end
    end
  end

  assign free_tag = RS_ID_WIDTH'(RS_BASE_ID)
                  + RS_ID_WIDTH'(free_idx);

  assign dispatch_ready = free_any;
  // When full the tag output freezes on the last offered tag.
  assign dispatch_rs_id = free_any ? free_tag : last_tag;
  assign disp_fire      = dispatch_valid && free_any;
  assign issue_fire     = rdy_any && issue_ready;

  // Issue outputs: selected entry, forced to zero when nothing is ready.
  always_comb begin
    issue_valid     = rdy_any;
    issue_opcode    = '0;
    issue_dest_addr = '0;
    issue_op_value  = '0;
    issue_rs_id     = '0;
    if (rdy_any) begin
      issue_opcode    = ent[rdy_idx].opcode;
      issue_dest_addr = ent[rdy_idx].dest;
      issue_op_value  = ent[rdy_idx].val;
      issue_rs_id     = RS_ID_WIDTH'(RS_BASE_ID)
                      + RS_ID_WIDTH'(rdy_idx);
    end
  end

  // Remember the last offered tag so it can be held while full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_tag <= RS_ID_WIDTH'(RS_BASE_ID);
    end else if (free_any) begin
      last_tag <= free_tag;
    end
  end

  // Entry update: snoop capture, issue release and dispatch write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        for (int k = 0; k < 2; k++) begin
          if (ent[i].busy && !ent[i].vld[k] && result_valid
              && (ent[i].tag[k] == result_rs_id)) begin
            ent[i].vld[k] <= 1'b1;
            ent[i].val[k] <= result_value;
          end
        end
        if (issue_fire && (IW'(i) == rdy_idx)) begin
          ent[i].busy <= 1'b0;
        end
        if (disp_fire && (IW'(i) == free_idx)) begin
          ent[i].busy   <= 1'b1;
          ent[i].opcode <= dispatch_opcode;
          ent[i].dest   <= dispatch_dest_addr;
          for (int k = 0; k < 2; k++) begin
            ent[i].tag[k] <= dispatch_op_rs_id[k];
            if (dispatch_op_valid[k]) begin
              ent[i].vld[k] <= 1'b1;
              ent[i].val[k] <= dispatch_op_value[k];
            end else if (result_valid
                         && (dispatch_op_rs_id[k] == result_rs_id)) begin
              ent[i].vld[k] <= 1'b1;
              ent[i].val[k] <= result_value;
            end else begin
              ent[i].vld[k] <= 1'b0;
              ent[i].val[k] <= '0;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_gp_reservation_station.sv
// Directed bench for gp_reservation_station (DEPTH=4, RS_BASE_ID=8).
// Inputs change 1 time unit after the rising edge; outputs are checked then.
module tb_gp_reservation_station;

  logic             clk = 1'b0;
  logic             rst;
  logic             dispatch_valid;
  logic             dispatch_ready;
  logic [4:0]       dispatch_rs_id;
  logic [5:0]       dispatch_opcode;
  logic [4:0]       dispatch_dest_addr;
  logic [1:0]       dispatch_op_valid;
  logic [1:0][31:0] dispatch_op_value;
  logic [1:0][4:0]  dispatch_op_rs_id;
  logic             result_valid;
  logic [4:0]       result_rs_id;
  logic [31:0]      result_value;
  logic             issue_valid;
  logic             issue_ready;
  logic [5:0]       issue_opcode;
  logic [4:0]       issue_dest_addr;
  logic [1:0][31:0] issue_op_value;
  logic [4:0]       issue_rs_id;

  int n_cmp = 0;
  int n_bad = 0;

  gp_reservation_station #(
    .DEPTH(4), .RS_ID_WIDTH(5), .RS_BASE_ID(8), .OPCODE_WIDTH(6)
  ) dut (
    .clk(clk), .rst(rst),
    .dispatch_valid(dispatch_valid),
    .dispatch_ready(dispatch_ready),
    .dispatch_rs_id(dispatch_rs_id),
    .dispatch_opcode(dispatch_opcode),
    .dispatch_dest_addr(dispatch_dest_addr),
    .dispatch_op_valid(dispatch_op_valid),
    .dispatch_op_value(dispatch_op_value),
    .dispatch_op_rs_id(dispatch_op_rs_id),
    .result_valid(result_valid),
    .result_rs_id(result_rs_id),
    .result_value(result_value),
    .issue_valid(issue_valid),
    .issue_ready(issue_ready),
    .issue_opcode(issue_opcode),
    .issue_dest_addr(issue_dest_addr),
    .issue_op_value(issue_op_value),
    .issue_rs_id(issue_rs_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic disp(input logic       v,
                      input logic [5:0] opc,
                      input logic [4:0] dst,
                      input logic       v0,
                      input logic [31:0] d0,
                      input logic [4:0] t0,
                      input logic       v1,
                      input logic [31:0] d1,
                      input logic [4:0] t1);
    dispatch_valid       = v;
    dispatch_opcode      = opc;
    dispatch_dest_addr   = dst;
    dispatch_op_valid    = {v1, v0};
    dispatch_op_value[0] = d0;
    dispatch_op_value[1] = d1;
    dispatch_op_rs_id[0] = t0;
    dispatch_op_rs_id[1] = t1;
  endtask

  task automatic bcast(input logic v,
                       input logic [4:0] t,
                       input logic [31:0] d);
    result_valid = v;
    result_rs_id = t;
    result_value = d;
  endtask

  initial begin
    rst = 1'b1;
    issue_ready = 1'b0;
    disp(0, 0, 0, 0, 0, 0, 0, 0, 0);
    bcast(0, 0, 0);
    #1;
    chk("rst_dready", 32'(dispatch_ready), 1);
    chk("rst_dtag", 32'(dispatch_rs_id), 8);
    chk("rst_ivalid", 32'(issue_valid), 0);
    chk("rst_iop0", issue_op_value[0], 0);
    #2 rst = 1'b0;
    step();

    // 1: both operands valid, issues the next cycle
    issue_ready = 1'b1;
    disp(1, 6'd1, 5'd3, 1, 32'd5, 0, 1, 32'd7, 0);
    chk("t1_dtag", 32'(dispatch_rs_id), 8);
    chk("t1_ivalid_pre", 32'(issue_valid), 0);
    step();
    disp(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("t1_ivalid", 32'(issue_valid), 1);
    chk("t1_op0", issue_op_value[0], 5);
    chk("t1_op1", issue_op_value[1], 7);
    chk("t1_itag", 32'(issue_rs_id), 8);
    chk("t1_dest", 32'(issue_dest_addr), 3);
    chk("t1_dtag_busy", 32'(dispatch_rs_id), 9);
    step();
    chk("t1_ivalid_post", 32'(issue_valid), 0);
    chk("t1_dtag_free", 32'(dispatch_rs_id), 8);

    // 2: operand 0 waits for tag 3
    disp(1, 6'd2, 5'd4, 0, 0, 5'd3, 1, 32'd9, 0);
    step();
    disp(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("t2_wait1", 32'(issue_valid), 0);
    step();
    chk("t2_wait2", 32'(issue_valid), 0);
    bcast(1, 5'd3, 32'h1234);
    chk("t2_bcast_cyc", 32'(issue_valid), 0);
    step();
    bcast(0, 0, 0);
    chk("t2_ivalid", 32'(issue_valid), 1);
    chk("t2_op0", issue_op_value[0], 32'h1234);
    chk("t2_op1", issue_op_value[1], 9);
    chk("t2_opc", 32'(issue_opcode), 2);
    chk("t2_dest", 32'(issue_dest_addr), 4);
    step();
    chk("t2_drained", 32'(issue_valid), 0);

    // 3: dispatch bypass of a same-cycle broadcast
    disp(1, 6'd3, 5'd5, 0, 0, 5'd3, 1, 32'd1, 0);
    bcast(1, 5'd3, 32'hAA);
    step();
    disp(0, 0, 0, 0, 0, 0, 0, 0, 0);
    bcast(0, 0, 0);
    chk("t3_ivalid", 32'(issue_valid), 1);
    chk("t3_op0", issue_op_value[0], 32'hAA);
    step();
    chk("t3_drained", 32'(issue_valid), 0);

    // 4: fill, drop a 5th, one broadcast wakes all
    issue_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      disp(1, 6'(i), 5'd1, 0, 0, 5'd2, 0, 0, 5'd2);
      chk("t4_dtag", 32'(dispatch_rs_id), 32'(8 + i));
      step();
    end
    disp(1, 6'd9, 5'd1, 1, 32'd3, 0, 1, 32'd3, 0);
    chk("t4_full", 32'(dispatch_ready), 0);
    chk("t4_hold", 32'(dispatch_rs_id), 11);
    step();
    disp(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("t4_still_full", 32'(dispatch_ready), 0);
    chk("t4_none_rdy", 32'(issue_valid), 0);
    bcast(1, 5'd2, 32'd1);
    step();
    bcast(0, 0, 0);
    issue_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("t4_ivalid", 32'(issue_valid), 1);
      chk("t4_itag", 32'(issue_rs_id), 32'(8 + i));
      chk("t4_opc", 32'(issue_opcode), 32'(i));
      chk("t4_op1", issue_op_value[1], 1);
      step();
    end
    chk("t4_no5th", 32'(issue_valid), 0);
    chk("t4_empty", 32'(dispatch_ready), 1);

    // 5: backpressure stability and slot reuse timing
    issue_ready = 1'b0;
    disp(1, 6'd7, 5'd6, 1, 32'h11, 0, 1, 32'h22, 0);
    step();
    disp(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      chk("t5_hold_v", 32'(issue_valid), 1);
      chk("t5_hold_tag", 32'(issue_rs_id), 8);
      chk("t5_hold_op0", issue_op_value[0], 32'h11);
      chk("t5_hold_op1", issue_op_value[1], 32'h22);
      step();
    end
    issue_ready = 1'b1;
    disp(1, 6'd8, 5'd7, 1, 32'h33, 0, 1, 32'h44, 0);
    chk("t5_new_tag", 32'(dispatch_rs_id), 9);
    step();
    issue_ready = 1'b0;
    disp(1, 6'd9, 5'd8, 1, 32'h55, 0, 1, 32'h66, 0);
    chk("t5_reuse_tag", 32'(dispatch_rs_id), 8);
    chk("t5_next_itag", 32'(issue_rs_id), 9);
    chk("t5_next_op0", issue_op_value[0], 32'h33);
    step();
    disp(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("t5_lowest_first", 32'(issue_rs_id), 8);
    chk("t5_lowest_op0", issue_op_value[0], 32'h55);
    issue_ready = 1'b1;
    step();
    step();
    chk("t5_drained", 32'(issue_valid), 0);

    // foreign tag has no effect on a pending operand
    issue_ready = 1'b0;
    disp(1, 6'd1, 5'd1, 0, 0, 5'd3, 1, 32'd2, 0);
    step();
    disp(0, 0, 0, 0, 0, 0, 0, 0, 0);
    bcast(1, 5'd20, 32'hDEAD);
    step();
    bcast(0, 0, 0);
    chk("foreign_tag", 32'(issue_valid), 0);

    // 6: async reset with 3 more busy entries
    for (int i = 0; i < 3; i++) begin
      disp(1, 6'd4, 5'd2, 1, 32'd8, 0, 1, 32'd9, 0);
      step();
    end
    disp(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("t6_pre_ivalid", 32'(issue_valid), 1);
    chk("t6_pre_full", 32'(dispatch_ready), 0);
    #2 rst = 1'b1;
    #1;
    chk("t6_ivalid", 32'(issue_valid), 0);
    chk("t6_dready", 32'(dispatch_ready), 1);
    chk("t6_dtag", 32'(dispatch_rs_id), 8);
    chk("t6_op0", issue_op_value[0], 0);
    chk("t6_itag", 32'(issue_rs_id), 0);
    step();
    rst = 1'b0;
    step();
    chk("t6_after", 32'(issue_valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
